// File: rtl/jpeg_quant_zigzag.sv
// jpeg_quant_zigzag
//   Wishbone slave that sits after the 2-D DCT. Software loads 64 signed
//   coefficients in natural row-major order. The block quantises each one by
//   multiplying with a per-entry reciprocal of the quantiser step, stores the
//   results in zig-zag order and holds them for the entropy coder to read back.
//
//   Address map (word address, only ADR_I[7:0] decoded):
//     ADR_I[7:6]=00  coefficient window: write coef[n] (natural index),
//                    read quantised out[n] (zig-zag index), sign-extended
//     ADR_I[7:6]=01  reciprocal table recip[n] (natural index), read/write
//     ADR_I[7]=1     STATUS (read-only) = {30'b0, busy, done}
//
//   Ports
//     CLK_I   clock
//     RST_I   synchronous reset, active-high
//     DAT_I   write data
//     DAT_O   registered read data (zero for writes and rejected accesses)
//     ADR_I   word address
//     WE_I    write enable
//     STB_I   strobe
//     CYC_I   cycle valid
//     SEL_I   byte selects; only 4'b1111 has any effect
//     ACK_O   one-cycle acknowledge
//     DONE_O  high while quantised results are valid
//
//   Handshake: a transfer happens in a cycle with CYC_I & STB_I & !ACK_O.
//   ACK_O and DAT_O are registered from that cycle and ACK_O lasts exactly one
//   cycle, so a master holding STB_I sees an acknowledge every other cycle.
module jpeg_quant_zigzag #(
    parameter int COEF_W  = 12,
    parameter int RECIP_W = 16
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    input  logic [31:0] ADR_I,
    input  logic        WE_I,
    input  logic        STB_I,
    input  logic        CYC_I,
    input  logic [3:0]  SEL_I,
    output logic        ACK_O,
    output logic        DONE_O
);

    localparam int PROD_W = COEF_W + RECIP_W;

    // JPEG luminance quantiser steps, natural row-major order.
    localparam int Q_TBL [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    // Zig-zag position k -> natural index.
    localparam int ZZ_TBL [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_QUANT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [COEF_W-1:0]  coef_q  [64];
    logic [RECIP_W-1:0] recip_q [64];
    logic [COEF_W-1:0]  out_q   [64];

    logic [6:0]         cnt_q;      // 0..65 while in QUANT
    logic               s1_vld;
    logic [5:0]         s1_k;
    logic [COEF_W-1:0]  s1_c;
    logic [RECIP_W-1:0] s1_r;

    logic               xfer, sel_ok, busy, done;
    logic [5:0]         idx, zz_idx;
    logic               coef_wr, recip_wr;
    logic [31:0]        rd_data;
    logic [COEF_W-1:0]  abs_c, q_mag, q_val;
    logic [PROD_W-1:0]  prod;
    logic               unused_bits;

    assign unused_bits = ^{ADR_I[31:8], DAT_I[31:RECIP_W]};

    assign xfer   = CYC_I & STB_I & ~ACK_O;
    assign sel_ok = (SEL_I == 4'b1111);
    assign idx    = ADR_I[5:0];
    assign busy   = (state_q == ST_QUANT);
    assign done   = (state_q == ST_DONE);
    assign DONE_O = done;
    assign zz_idx = 6'(ZZ_TBL[cnt_q[5:0]]);

    // Table writes are only honoured outside the quantisation pass.
    assign coef_wr  = xfer & sel_ok & WE_I & (ADR_I[7:6] == 2'b00) & ~busy;
    assign recip_wr = xfer & sel_ok & WE_I & (ADR_I[7:6] == 2'b01) & ~busy;

    // Stage 2: magnitude multiply, round half up on the magnitude (which is
    // half away from zero once the sign is restored).
    assign abs_c = s1_c[COEF_W-1] ? (~s1_c + 1'b1) : s1_c;
    assign prod  = PROD_W'(abs_c) * PROD_W'(s1_r);
    assign q_mag = COEF_W'((prod + PROD_W'(32'h8000)) >> 16);
    assign q_val = s1_c[COEF_W-1] ? (~q_mag + 1'b1) : q_mag;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:  if (coef_wr && idx == 6'd63) state_d = ST_QUANT;
            ST_QUANT: if (cnt_q == 7'd65) state_d = ST_DONE;
            ST_DONE:  if (coef_wr) state_d = (idx == 6'd63) ? ST_QUANT : ST_LOAD;
            default:  state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        rd_data = '0;
        if (sel_ok) begin
            if (ADR_I[7])
                rd_data = {30'b0, busy, done};
            else if (ADR_I[6])
                rd_data = {{(32-RECIP_W){1'b0}}, recip_q[idx]};
            else if (!busy)
                rd_data = {{(32-COEF_W){out_q[idx][COEF_W-1]}}, out_q[idx]};
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            s1_vld  <= 1'b0;
            s1_k    <= '0;
            s1_c    <= '0;
            s1_r    <= '0;
            ACK_O   <= 1'b0;
            DAT_O   <= '0;
            for (int i = 0; i < 64; i++) begin
                coef_q[i]  <= '0;
                out_q[i]   <= '0;
                recip_q[i] <= RECIP_W'((65536 + Q_TBL[i] / 2) / Q_TBL[i]);
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= busy ? cnt_q + 7'd1 : 7'd0;

            // Stage 1: fetch coefficient and reciprocal in zig-zag order.
            s1_vld  <= busy && (cnt_q < 7'd64);
            s1_k    <= cnt_q[5:0];
            s1_c    <= coef_q[zz_idx];
            s1_r    <= recip_q[zz_idx];

            if (s1_vld)
                out_q[s1_k] <= q_val;
            if (coef_wr)
                coef_q[idx] <= DAT_I[COEF_W-1:0];
            if (recip_wr)
                recip_q[idx] <= DAT_I[RECIP_W-1:0];

            ACK_O <= xfer;
            DAT_O <= (xfer && !WE_I) ? rd_data : 32'd0;
        end
    end

endmodule

// File: tb/tb_jpeg_quant_zigzag.sv
`timescale 1ns/1ps
module tb_jpeg_quant_zigzag;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [31:0] adr_i = '0;
    logic        we_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        cyc_i = 1'b0;
    logic [3:0]  sel_i = 4'hF;
    logic        ack_o;
    logic        done_o;

    always #5 clk = ~clk;

    jpeg_quant_zigzag dut (
        .CLK_I  (clk),
        .RST_I  (rst),
        .DAT_I  (dat_i),
        .DAT_O  (dat_o),
        .ADR_I  (adr_i),
        .WE_I   (we_i),
        .STB_I  (stb_i),
        .CYC_I  (cyc_i),
        .SEL_I  (sel_i),
        .ACK_O  (ack_o),
        .DONE_O (done_o)
    );

    localparam int QT [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };
    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    int m_coef  [64];
    int m_recip [64];

    // Reference quantiser: round(|c|*r / 2^16) half up, sign restored.
    function automatic int model_q(input int c, input int r);
        int a, q;
        a = (c < 0) ? -c : c;
        q = (a * r + 32768) / 65536;
        return (c < 0) ? -q : q;
    endfunction

    // ---------------- clock/reset and drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m_coef[i]  = 0;
            m_recip[i] = (65536 + QT[i] / 2) / QT[i];
        end
    endtask

    task automatic bus_xfer(input logic we, input logic [7:0] adr, input logic [31:0] wdat,
                            input logic [3:0] sel, output logic [31:0] rdat);
        bit got_ack;
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we;
        adr_i = {24'b0, adr}; dat_i = wdat; sel_i = sel;
        got_ack = 1'b0;
        rdat = 'x;
        for (int t = 0; t < 8 && !got_ack; t++) begin
            @(posedge clk); #1;
            if (ack_o) begin
                got_ack = 1'b1;
                rdat = dat_o;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = 4'hF;
        if (!got_ack) begin
            n_checks++;
            $display("FAIL bus_ack_timeout: adr %h got no ACK expected ACK within 8 cycles", adr);
        end
    endtask

    task automatic wr_coef(input int n, input int val);
        logic [31:0] d;
        bus_xfer(1'b1, 8'(n), 32'(val), 4'hF, d);
        m_coef[n] = val;
    endtask

    task automatic wr_recip(input int n, input int val);
        logic [31:0] d;
        bus_xfer(1'b1, 8'h40 | 8'(n), 32'(val), 4'hF, d);
        m_recip[n] = val;
    endtask

    // Returns cycles until DONE_O, or -1 if it never came.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done_o && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done_o) cyc = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] got, exp;
        do_reset();
        @(negedge clk);
        n_checks++;
        if (ack_o !== 1'b0 || dat_o !== 32'd0 || done_o !== 1'b0)
            $display("FAIL reset_outputs: got ack=%b dat=%h done=%b expected 0/0/0", ack_o, dat_o, done_o);
        else n_pass++;

        exp_q.push_back(32'd0);
        bus_xfer(1'b0, 8'h80, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL reset_status: got %h expected %h", got, exp); else n_pass++;

        exp_q.push_back(32'd4096);
        bus_xfer(1'b0, 8'h40, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL reset_recip0: got %h expected %h", got, exp); else n_pass++;

        exp_q.push_back(32'd5461);
        bus_xfer(1'b0, 8'h48, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL reset_recip8: got %h expected %h", got, exp); else n_pass++;

        exp_q.push_back(32'd0);
        bus_xfer(1'b0, 8'h00, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL reset_out0: got %h expected %h", got, exp); else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] got, exp;
        int cyc;
        do_reset();
        for (int i = 0; i < 64; i++) wr_coef(i, (i == 0) ? 100 : 0);
        wait_done(cyc);
        n_checks++;
        if (cyc < 1 || cyc > 66) $display("FAIL basic_latency: got %0d cycles expected 1..66", cyc);
        else n_pass++;
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back((k == 0) ? 32'd6 : 32'd0);
            bus_xfer(1'b0, 8'(k), 32'd0, 4'hF, got);
            exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) $display("FAIL basic_out[%0d]: got %h expected %h", k, got, exp); else n_pass++;
        end
    endtask

    task automatic test_rounding();
        logic [31:0] got, exp;
        int cyc;
        wr_coef(0, -100);
        wr_coef(8, 60);
        wr_coef(63, 0);
        wait_done(cyc);
        n_checks++;
        if (cyc < 0) $display("FAIL round_done: got timeout expected DONE_O"); else n_pass++;

        exp_q.push_back(32'hFFFF_FFFA);
        bus_xfer(1'b0, 8'h00, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL round_neg100: got %h expected %h", got, exp); else n_pass++;

        exp_q.push_back(32'd5);
        bus_xfer(1'b0, 8'h02, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL round_60_q12: got %h expected %h", got, exp); else n_pass++;

        wr_coef(0, 8);
        wr_coef(63, 0);
        wait_done(cyc);
        exp_q.push_back(32'd1);
        bus_xfer(1'b0, 8'h00, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL round_half_pos: got %h expected %h", got, exp); else n_pass++;

        wr_coef(0, -8);
        wr_coef(63, 0);
        wait_done(cyc);
        exp_q.push_back(32'hFFFF_FFFF);
        bus_xfer(1'b0, 8'h00, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL round_half_neg: got %h expected %h", got, exp); else n_pass++;
    endtask

    task automatic test_q2();
        logic [31:0] got, exp;
        int cyc;
        wr_recip(0, 32768);
        exp_q.push_back(32'd32768);
        bus_xfer(1'b0, 8'h40, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL q2_recip_rd: got %h expected %h", got, exp); else n_pass++;

        wr_coef(0, -2048);
        wr_coef(63, 0);
        wait_done(cyc);
        exp_q.push_back(32'hFFFF_FC00);
        bus_xfer(1'b0, 8'h00, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL q2_min: got %h expected %h", got, exp); else n_pass++;

        wr_coef(0, 2047);
        wr_coef(63, 0);
        wait_done(cyc);
        exp_q.push_back(32'd1024);
        bus_xfer(1'b0, 8'h00, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL q2_max: got %h expected %h", got, exp); else n_pass++;

        do_reset();
        exp_q.push_back(32'd4096);
        bus_xfer(1'b0, 8'h40, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL q2_recip_restored: got %h expected %h", got, exp); else n_pass++;
    endtask

    task automatic test_mid_quant();
        logic [31:0] got, exp;
        int cyc;
        do_reset();
        wr_coef(0, 100);
        wr_coef(63, 0);
        exp_q.push_back(32'd2);
        bus_xfer(1'b0, 8'h80, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL mid_status: got %h expected %h", got, exp); else n_pass++;

        bus_xfer(1'b1, 8'd63, 32'd1000, 4'hF, got);   // must be ignored

        exp_q.push_back(32'd5461);
        bus_xfer(1'b0, 8'h48, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL mid_recip_rd: got %h expected %h", got, exp); else n_pass++;

        exp_q.push_back(32'd0);
        bus_xfer(1'b0, 8'h00, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL mid_out_rd: got %h expected %h", got, exp); else n_pass++;

        wait_done(cyc);
        exp_q.push_back(32'd6);
        bus_xfer(1'b0, 8'h00, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL mid_after_out0: got %h expected %h", got, exp); else n_pass++;

        exp_q.push_back(32'd0);
        bus_xfer(1'b0, 8'd63, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL mid_ignored_write: got %h expected %h", got, exp); else n_pass++;

        wr_coef(63, 0);   // DONE -> QUANT directly
        exp_q.push_back(32'd2);
        bus_xfer(1'b0, 8'h80, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL mid_requant_status: got %h expected %h", got, exp); else n_pass++;

        do_reset();
        @(negedge clk);
        n_checks++;
        if (done_o !== 1'b0) $display("FAIL abort_done: got %b expected 0", done_o); else n_pass++;

        exp_q.push_back(32'd0);
        bus_xfer(1'b0, 8'h80, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL abort_status: got %h expected %h", got, exp); else n_pass++;

        exp_q.push_back(32'd0);
        bus_xfer(1'b0, 8'h00, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL abort_out0: got %h expected %h", got, exp); else n_pass++;
    endtask

    task automatic test_handshake();
        logic [31:0] got, exp;
        logic exp_ack;
        do_reset();
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h80; sel_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            exp_ack = (i % 2 == 0);
            n_checks++;
            if (ack_o !== exp_ack) $display("FAIL hs_ack[%0d]: got %b expected %b", i, ack_o, exp_ack);
            else n_pass++;
        end
        cyc_i = 1'b0; stb_i = 1'b0;

        bus_xfer(1'b1, 8'h40, 32'd1, 4'b0011, got);
        bus_xfer(1'b1, 8'd63, 32'd0, 4'b0011, got);
        exp_q.push_back(32'd4096);
        bus_xfer(1'b0, 8'h40, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL sel_write_ignored: got %h expected %h", got, exp); else n_pass++;

        exp_q.push_back(32'd0);
        bus_xfer(1'b0, 8'h80, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL sel_no_pass: got %h expected %h", got, exp); else n_pass++;

        exp_q.push_back(32'd0);
        bus_xfer(1'b0, 8'h40, 32'd0, 4'b0011, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL sel_read_zero: got %h expected %h", got, exp); else n_pass++;
    endtask

    task automatic test_done_reload();
        logic [31:0] got, exp;
        int cyc;
        do_reset();
        wr_coef(0, 100);
        wr_coef(63, 0);
        wait_done(cyc);
        wr_coef(5, 200);
        n_checks++;
        if (done_o !== 1'b0) $display("FAIL reload_done_o: got %b expected 0", done_o); else n_pass++;
        exp_q.push_back(32'd0);
        bus_xfer(1'b0, 8'h80, 32'd0, 4'hF, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL reload_status: got %h expected %h", got, exp); else n_pass++;

        wr_coef(63, 0);
        wait_done(cyc);
        n_checks++;
        if (cyc < 0) $display("FAIL reload_pass_done: got timeout expected DONE_O"); else n_pass++;
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(32'(model_q(m_coef[ZZ[k]], m_recip[ZZ[k]])));
            bus_xfer(1'b0, 8'(k), 32'd0, 4'hF, got);
            exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) $display("FAIL reload_out[%0d]: got %h expected %h", k, got, exp); else n_pass++;
        end
    endtask

    task automatic test_random_pass();
        logic [31:0] got, exp;
        int cyc, n;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(0, 63);
            wr_recip(n, $urandom_range(2048, 32768));
        end
        for (int i = 0; i < 64; i++) wr_coef(i, int'($urandom_range(0, 4095)) - 2048);
        wait_done(cyc);
        n_checks++;
        if (cyc < 0) $display("FAIL rand_pass_done: got timeout expected DONE_O"); else n_pass++;
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(32'(model_q(m_coef[ZZ[k]], m_recip[ZZ[k]])));
            bus_xfer(1'b0, 8'(k), 32'd0, 4'hF, got);
            exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) $display("FAIL rand_out[%0d]: got %h expected %h", k, got, exp); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_q2();
        test_mid_quant();
        test_handshake();
        test_done_reload();
        test_random_pass();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
